// File: rtl/param_sp_ram_pkg.sv
// Shared constants, FSM state type and parity helper for param_sp_ram.
// Parity storage is enabled by defining PARAM_SP_RAM_PARITY_EN.
package param_sp_ram_pkg;

  localparam int WR_NO_CHANGE   = 0;
  localparam int WR_READ_FIRST  = 1;
  localparam int WR_WRITE_FIRST = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Even parity: stored bit makes the byte plus bit carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_clr_ctrl.sv
// Clear engine for param_sp_ram: INIT/IDLE FSM that walks every word once,
// driving a write-zero port, and reports ready when the array is usable.
module sp_ram_clr_ctrl
  import param_sp_ram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output state_e            state_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign clr_we   = (state_q == ST_INIT);
  assign clr_addr = cnt_q;
  assign state_o  = state_q;

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM with byte enables, selectable read-during-write
// mode, 1/2-cycle read latency and a clear engine. Optional: PARAM_SP_RAM_PARITY_EN.
module param_sp_ram
  import param_sp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1,
  parameter int WR_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic                  ready,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid
`ifdef PARAM_SP_RAM_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int NB = DATA_W / 8;

  // Handshake: an access is taken on a rising edge with en=1 while ready=1 and
  // clr=0; reads (and moded writes) pulse dout_valid READ_LAT cycles later.
  // There is no backpressure on the output side and no queuing when ready=0.
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  state_e            clr_state;

  sp_ram_clr_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state_o  (clr_state)
  );

  logic              acc, in_range, wr_en;
  logic [DATA_W-1:0] old_word, merged;
  logic              p_valid;
  logic [DATA_W-1:0] p_data;

  assign acc      = en & (clr_state == ST_IDLE) & ~clr;
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign wr_en    = acc & we & in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
      end
    end
  end

  assign old_word = in_range ? mem[addr] : '0;

  always_comb begin
    merged = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) merged[8*k +: 8] = din[8*k +: 8];
    end
  end

`ifdef PARAM_SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] old_par;
  logic          old_perr, p_perr;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) par_mem[addr][k] <= byte_parity(din[8*k +: 8]);
      end
    end
  end

  assign old_par = in_range ? par_mem[addr] : '0;

  always_comb begin
    old_perr = 1'b0;
    for (int k = 0; k < NB; k++) begin
      old_perr = old_perr | (byte_parity(old_word[8*k +: 8]) != old_par[k]);
    end
  end
`endif

  always_comb begin
    p_valid = 1'b0;
    p_data  = old_word;
`ifdef PARAM_SP_RAM_PARITY_EN
    p_perr  = old_perr;
`endif
    if (acc) begin
      if (!we) begin
        p_valid = 1'b1;
      end else begin
        case (WR_MODE)
          WR_NO_CHANGE:  p_valid = 1'b0;
          WR_READ_FIRST: p_valid = 1'b1;
          WR_WRITE_FIRST: begin
            // Bypass data never came from the array, so it cannot flag parity.
            p_valid = 1'b1;
            p_data  = in_range ? merged : '0;
`ifdef PARAM_SP_RAM_PARITY_EN
            p_perr  = 1'b0;
`endif
          end
          default: p_valid = 1'b0;
        endcase
      end
    end
  end

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
`ifdef PARAM_SP_RAM_PARITY_EN
  logic              s1_perr_q, s1_perr_d;
`endif

  always_comb begin
    s1_valid_d = p_valid;
    s1_data_d  = p_valid ? p_data : s1_data_q;
`ifdef PARAM_SP_RAM_PARITY_EN
    s1_perr_d  = p_valid & p_perr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
`ifdef PARAM_SP_RAM_PARITY_EN
      s1_perr_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
`ifdef PARAM_SP_RAM_PARITY_EN
      s1_perr_q  <= s1_perr_d;
`endif
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
`ifdef PARAM_SP_RAM_PARITY_EN
    logic              s2_perr_q, s2_perr_d;
`endif

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
`ifdef PARAM_SP_RAM_PARITY_EN
      s2_perr_d  = s1_perr_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
`ifdef PARAM_SP_RAM_PARITY_EN
        s2_perr_q  <= 1'b0;
`endif
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
`ifdef PARAM_SP_RAM_PARITY_EN
        s2_perr_q  <= s2_perr_d;
`endif
      end
    end

    assign dout       = s2_data_q;
    assign dout_valid = s2_valid_q;
`ifdef PARAM_SP_RAM_PARITY_EN
    assign par_err    = s2_perr_q;
`endif
  end else begin : g_lat1
    assign dout       = s1_data_q;
    assign dout_valid = s1_valid_q;
`ifdef PARAM_SP_RAM_PARITY_EN
    assign par_err    = s1_perr_q;
`endif
  end

endmodule

// File: tb/tb_param_sp_ram.sv
// Drives three param_sp_ram configurations in lockstep and checks every output
// cycle against a reference memory and per-instance expected queues.
module tb_param_sp_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] din = 32'h0;

  logic [7:0]  dout0, dout2;
  logic [31:0] dout1;
  logic        rdy0, rdy1, rdy2, v0, v1, v2;
`ifdef PARAM_SP_RAM_PARITY_EN
  logic        pe0, pe1, pe2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q [3][$];
  int          due_q [3][$];
  logic        par_q [$];
  logic [31:0] last_out [3];
  logic [31:0] mdl [3][16];
  logic        poison [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: 8-bit NO_CHANGE, u1: 32-bit DEPTH=12 READ_LAT=2 READ_FIRST, u2: 8-bit WRITE_FIRST
  param_sp_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LAT(1), .WR_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .we(we), .be(be[0:0]), .addr(addr),
    .din(din[7:0]), .ready(rdy0), .dout(dout0), .dout_valid(v0)
`ifdef PARAM_SP_RAM_PARITY_EN
    , .par_err(pe0)
`endif
  );

  param_sp_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .READ_LAT(2), .WR_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .we(we), .be(be), .addr(addr),
    .din(din), .ready(rdy1), .dout(dout1), .dout_valid(v1)
`ifdef PARAM_SP_RAM_PARITY_EN
    , .par_err(pe1)
`endif
  );

  param_sp_ram #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LAT(1), .WR_MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .we(we), .be(be[0:0]), .addr(addr),
    .din(din[7:0]), .ready(rdy2), .dout(dout2), .dout_valid(v2)
`ifdef PARAM_SP_RAM_PARITY_EN
    , .par_err(pe2)
`endif
  );

  function automatic int dep(input int id);
    return (id == 1) ? 12 : 16;
  endfunction

  function automatic int lat(input int id);
    return (id == 1) ? 2 : 1;
  endfunction

  function automatic int lanes(input int id);
    return (id == 1) ? 4 : 1;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? rdy0 : (id == 1) ? rdy1 : rdy2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] v, input logic p);
    exp_q[id].push_back(v);
    due_q[id].push_back(cyc + lat(id));
    if (id == 1) par_q.push_back(p);
  endtask

  task automatic model_clear();
    for (int id = 0; id < 3; id++)
      for (int a = 0; a < 16; a++) mdl[id][a] = 32'h0;
    for (int a = 0; a < 16; a++) poison[a] = 1'b0;
  endtask

  task automatic flush_queues();
    for (int id = 0; id < 3; id++) begin
      exp_q[id].delete();
      due_q[id].delete();
      last_out[id] = 32'h0;
    end
    par_q.delete();
  endtask

  // Reference behaviour of one accepted access on one instance.
  task automatic model_acc(input int id, input logic w, input logic [3:0] b,
                           input logic [3:0] a, input logic [31:0] d);
    logic [31:0] old, mrg, mask;
    logic        inr, p;
    inr  = (int'(a) < dep(id));
    old  = inr ? mdl[id][a] : 32'h0;
    p    = inr & poison[a];
    mask = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < lanes(id) && b[k]) mask[8*k +: 8] = 8'hff;
    mrg = (old & ~mask) | (d & mask);
    if (!w) begin
      push(id, old, p);
    end else begin
      if (inr) mdl[id][a] = mrg;
      if (id == 1) begin
        push(id, old, p);
        if (inr && b[0]) poison[a] = 1'b0;
      end else if (id == 2) begin
        push(id, mrg, 1'b0);
      end
    end
  endtask

  task automatic acc(input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    en = 1'b1; we = w; be = b; addr = a; din = d;
    for (int id = 0; id < 3; id++) model_acc(id, w, b, a, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0; we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at the negedge where the clear trigger was driven; optionally keeps
  // poking writes of all-ones while ready is low, all of which must be dropped.
  task automatic wait_ready(input int extra, input logic poke);
    int first [3];
    for (int id = 0; id < 3; id++) first[id] = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      clr = 1'b0;
      en = poke && (n <= 8);
      we = 1'b1; be = 4'hf; addr = 4'(n); din = 32'hffff_ffff;
      for (int id = 0; id < 3; id++)
        if (first[id] == 0 && rdy(id)) first[id] = n;
    end
    en = 1'b0; we = 1'b0;
    for (int id = 0; id < 3; id++)
      chk($sformatf("u%0d_ready_first_cycle", id), first[id], dep(id) + extra);
  endtask

  task automatic check_port(input int id, input logic v, input logic [31:0] d, input logic pe);
    logic [31:0] e;
    logic        ep;
    if (!rst_n) begin
      chk($sformatf("u%0d_rst_dout", id), d, 32'h0);
      chk($sformatf("u%0d_rst_valid", id), {31'h0, v}, 32'h0);
      last_out[id] = 32'h0;
    end else if (due_q[id].size() > 0 && due_q[id][0] == cyc) begin
      e = exp_q[id].pop_front();
      void'(due_q[id].pop_front());
      ep = (id == 1) ? par_q.pop_front() : 1'b0;
      chk($sformatf("u%0d_valid", id), {31'h0, v}, 32'h1);
      chk($sformatf("u%0d_dout", id), d, e);
`ifdef PARAM_SP_RAM_PARITY_EN
      chk($sformatf("u%0d_par_err", id), {31'h0, pe}, {31'h0, ep});
`else
      if (pe !== 1'b0 || ep !== 1'b0) chk($sformatf("u%0d_par_off", id), {31'h0, pe}, {31'h0, ep});
`endif
      last_out[id] = e;
    end else begin
      chk($sformatf("u%0d_no_valid", id), {31'h0, v}, 32'h0);
      chk($sformatf("u%0d_hold", id), d, last_out[id]);
`ifdef PARAM_SP_RAM_PARITY_EN
      chk($sformatf("u%0d_par_idle", id), {31'h0, pe}, 32'h0);
`endif
    end
  endtask

  always @(negedge clk) begin
`ifdef PARAM_SP_RAM_PARITY_EN
    check_port(0, v0, {24'h0, dout0}, pe0);
    check_port(1, v1, dout1, pe1);
    check_port(2, v2, {24'h0, dout2}, pe2);
`else
    check_port(0, v0, {24'h0, dout0}, 1'b0);
    check_port(1, v1, dout1, 1'b0);
    check_port(2, v2, {24'h0, dout2}, 1'b0);
`endif
  end

  initial begin
    flush_queues();
    model_clear();

    // Reset, release, and poke writes during INIT that must be ignored
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0, 1'b1);

    // Every address reads zero after the power-up clear
    for (int a = 0; a < 16; a++) acc(1'b0, 4'hf, 4'(a), 32'h0);
    idle(3);

    // Byte enables
    acc(1'b1, 4'b1111, 4'd3, 32'hAABB_CCDD);
    acc(1'b1, 4'b0101, 4'd3, 32'h1122_3344);
    acc(1'b0, 4'hf, 4'd3, 32'h0);
    idle(3);

    // Read-during-write: addr 5 holds 0x12, then 0x34 is written
    acc(1'b1, 4'hf, 4'd5, 32'h12);
    acc(1'b0, 4'hf, 4'd5, 32'h0);
    idle(2);
    acc(1'b1, 4'hf, 4'd5, 32'h34);
    idle(3);
    acc(1'b0, 4'hf, 4'd5, 32'h0);
    idle(3);

    // Streaming reads after writes
    acc(1'b1, 4'hf, 4'd0, 32'hA0);
    acc(1'b1, 4'hf, 4'd1, 32'hA1);
    acc(1'b1, 4'hf, 4'd2, 32'hA2);
    acc(1'b0, 4'hf, 4'd0, 32'h0);
    acc(1'b0, 4'hf, 4'd1, 32'h0);
    acc(1'b0, 4'hf, 4'd2, 32'h0);
    idle(3);

    // Random mixed traffic, including out-of-range addresses on the 12-deep RAM
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      acc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
    end
    idle(3);

    // Out-of-range write then read
    acc(1'b1, 4'hf, 4'd13, 32'h5A5A_5A5A);
    acc(1'b0, 4'hf, 4'd13, 32'h0);
    idle(3);

`ifdef PARAM_SP_RAM_PARITY_EN
    acc(1'b1, 4'hf, 4'd2, 32'hC3C3_C3C3);
    idle(2);
    u1.par_mem[2][0] = ~u1.par_mem[2][0];
    poison[2] = 1'b1;
    acc(1'b0, 4'hf, 4'd2, 32'h0);
    idle(3);
`endif

    // clr in IDLE with a read in flight and a dropped read on the clr cycle
    acc(1'b1, 4'hf, 4'd7, 32'h7777_7777);
    acc(1'b0, 4'hf, 4'd7, 32'h0);
    clr = 1'b1; en = 1'b1; we = 1'b0; addr = 4'd4;
    model_clear();
    wait_ready(1, 1'b0);
    for (int a = 0; a < 16; a++) acc(1'b0, 4'hf, 4'(a), 32'h0);
    idle(3);

    // Second clr at cycle 8 of INIT restarts the full sweep
    clr = 1'b1;
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    repeat (7) @(negedge clk);
    chk("ready_low_mid_init", {29'h0, rdy0, rdy1, rdy2}, 32'h0);
    clr = 1'b1;
    wait_ready(1, 1'b0);

    // Reset asserted mid-INIT forces dout and ready low immediately
    acc(1'b1, 4'hf, 4'd7, 32'h7777_7777);
    acc(1'b0, 4'hf, 4'd7, 32'h0);
    idle(3);
    clr = 1'b1;
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    flush_queues();
    #1;
    chk("async_rst_dout0", {24'h0, dout0}, 32'h0);
    chk("async_rst_dout1", dout1, 32'h0);
    chk("async_rst_dout2", {24'h0, dout2}, 32'h0);
    chk("async_rst_ready", {29'h0, rdy0, rdy1, rdy2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(0, 1'b0);
    for (int a = 5; a < 9; a++) acc(1'b0, 4'hf, 4'(a), 32'h0);
    idle(4);

    for (int id = 0; id < 3; id++)
      chk($sformatf("u%0d_drain", id), exp_q[id].size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sp_ram.md
Name: param_sp_ram

Overview:
- Parametrised single-port synchronous RAM; successor to the team's fixed 16x8 single-port RAM.
- Adds configurable width and depth, per-byte write enables, selectable read-during-write mode, and 1- or 2-cycle read latency.
- Adds a hardware clear engine that zeroes the array after reset and on request, with a ready handshake.
- Sits between a local master (register file, DMA, small CPU) and on-chip storage.

Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words; DEPTH <= 2**ADDR_W.
- READ_LAT, 1: read latency in cycles; legal values 1 or 2.
- WR_MODE, 0: read-during-write behaviour; 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST.
- NB, DATA_W/8: byte lanes; localparam, not overridable.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  one-cycle pulse; restarts the clear engine.
- en  in  1  access request; accepted only when ready=1.
- we  in  1  1 = write, 0 = read; qualified by en.
- be  in  NB  byte enables for writes; bit k covers din[8k+7:8k].
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- ready  out  1  1 = IDLE; accesses are accepted.
- dout  out  DATA_W  read data.
- dout_valid  out  1  one-cycle pulse marking new dout.

Behaviour:
- Reset (rst_n=0, asynchronous): state=INIT, clear counter=0, ready=0, dout=0, dout_valid=0, read pipeline flushed. Memory contents are not reset asynchronously.
- FSM has two states, INIT and IDLE.
  - INIT: writes 0 to word cnt each cycle, then cnt+1. After cnt=DEPTH-1 is written, go to IDLE next cycle. A full clear takes exactly DEPTH cycles.
  - IDLE: ready=1. clr=1 goes to INIT with cnt=0; the access presented in that same cycle is dropped.
  - clr during INIT restarts cnt at 0.
- Accepted access: en & ready. When ready=0, en is ignored; no queuing, no dout_valid.
- Write: for each k with be[k]=1, mem[addr] byte k <= din byte k; other bytes keep their value. be=0 writes nothing but still counts for WR_MODE output.
- Read: dout and dout_valid update READ_LAT cycles after acceptance.
  - READ_LAT=2 registers the array output once more.
  - Back-to-back reads give one result per cycle.
- Read-during-write output, per WR_MODE:
  - NO_CHANGE: dout holds, no dout_valid.
  - READ_FIRST: old word output with dout_valid.
  - WRITE_FIRST: merged new word output with dout_valid.
- Out-of-range address (addr >= DEPTH): write ignored; read returns dout=0 with dout_valid.
- Between reads, dout holds its last value. In INIT it holds, except that reset forces 0.
- Reset mid-read: the pending dout_valid is lost.
- Entering INIT via clr does not flush an in-flight read; it completes on schedule.

Optional Feature:
- Macro PARAM_SP_RAM_PARITY_EN.
- Defined:
  - One even-parity bit stored per byte lane, written with its byte; the clear engine writes parity 0.
  - Extra output port par_err (width 1) is asserted together with dout_valid when any read byte's recomputed parity mismatches its stored bit.
  - par_err resets to 0.
  - WRITE_FIRST bypass data never flags.
- Undefined: no parity storage and no par_err port.

Decomposition:
- Package param_sp_ram_pkg holds:
  - WR_MODE constants: WR_NO_CHANGE=0, WR_READ_FIRST=1, WR_WRITE_FIRST=2.
  - State enum: ST_INIT, ST_IDLE.
  - Function for parity of a byte.
- One sub-module, sp_ram_clr_ctrl: INIT/IDLE FSM and clear counter. Outputs ready, clear write enable and clear address. The top module muxes between the clear port and the user port.

Test Plan:
- Reset then idle, defaults: release rst_n. Required: ready=0 for exactly 16 cycles then 1; every address reads 0x00 with dout_valid 1 cycle after en.
- Byte enables, DATA_W=32: write 0xAABBCCDD at addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101. Required: read addr 3 gives 0xAA22CC44.
- WR_MODE sweep: addr 5 holds 0x12; write 0x34 to it. Required: NO_CHANGE gives no dout_valid and dout unchanged; READ_FIRST gives 0x12 with valid; WRITE_FIRST gives 0x34 with valid.
- READ_LAT=2 streaming: reads of addr 0,1,2 on consecutive cycles, after writing 0xA0,0xA1,0xA2. Required: dout 0xA0,0xA1,0xA2 on cycles +2,+3,+4 with dout_valid continuous.
- clr and reset mid-operation:
  - Pulse clr in IDLE. Required: ready low 16 cycles; all words read 0.
  - Pulse clr again at cycle 8 of INIT. Required: ready low a further 16 cycles.
  - Assert rst_n=0 mid-INIT. Required: dout=0 and ready=0 immediately.
- Out-of-range and parity, DEPTH=12, macro defined: write addr 13, then read addr 13. Required: dout=0 with valid.
  - Force a flipped stored bit at addr 2, then read addr 2. Required: par_err=1 coincident with dout_valid.
